// File: rtl/fir_serial_to_unfolded.sv
// fir_serial_to_unfolded: packs three valid serial samples into one unfolded word,
// with a flush that emits a zero-padded partial group.
module fir_serial_to_unfolded #(
    parameter int NBIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBIT-1:0] din,
    input  logic            vin,
    input  logic            flush,
    output logic [NBIT-1:0] dout3k,
    output logic [NBIT-1:0] dout3k1,
    output logic [NBIT-1:0] dout3k2,
    output logic            vout,
    output logic            partial,
    output logic [1:0]      phase
);
    logic [NBIT-1:0] h0, h1;
    logic            full, pad;

    assign full = vin && phase == 2'd2;
    assign pad  = flush && (vin || phase != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0      <= '0;
            h1      <= '0;
            dout3k  <= '0;
            dout3k1 <= '0;
            dout3k2 <= '0;
            vout    <= 1'b0;
            partial <= 1'b0;
            phase   <= 2'd0;
        end else begin
            vout <= full || pad;
            if (vin && phase == 2'd0) h0 <= din;
            if (vin && phase == 2'd1) h1 <= din;
            if (full) begin
                dout3k  <= h0;
                dout3k1 <= h1;
                dout3k2 <= din;
                partial <= 1'b0;
                phase   <= 2'd0;
            end else if (pad) begin
                // padded lanes are forced to zero so stale holds never leak out
                dout3k  <= phase == 2'd0 ? din : h0;
                dout3k1 <= phase == 2'd2 ? h1 : (phase == 2'd1 && vin) ? din : '0;
                dout3k2 <= '0;
                partial <= 1'b1;
                phase   <= 2'd0;
            end else if (vin) begin
                phase <= phase + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_fir_serial_to_unfolded.sv
// tb_fir_serial_to_unfolded: directed stimulus against a sample-buffer model,
// checked every cycle plus literal expectations for each scenario.
module tb_fir_serial_to_unfolded;
    logic       clk, rst_n, vin, flush;
    logic [7:0] din, dout3k, dout3k1, dout3k2;
    logic       vout, partial;
    logic [1:0] phase;

    int vectors = 0, errors = 0, npulse = 0, p0;
    logic [7:0] cap0, cap1, cap2;
    logic       capp;

    logic [7:0] s [3];
    int         cnt;
    logic [7:0] e0, e1, e2;
    logic       ev, ep;

    fir_serial_to_unfolded #(.NBIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .vin(vin), .flush(flush),
        .dout3k(dout3k), .dout3k1(dout3k1), .dout3k2(dout3k2),
        .vout(vout), .partial(partial), .phase(phase)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt = 0; e0 = 0; e1 = 0; e2 = 0; ev = 0; ep = 0;
        end else begin
            ev = 0;
            if (vin) begin
                s[cnt] = din;
                cnt++;
            end
            if (cnt == 3 || (flush && cnt > 0)) begin
                e0 = s[0];
                e1 = cnt > 1 ? s[1] : 8'h00;
                e2 = cnt > 2 ? s[2] : 8'h00;
                ep = cnt < 3;
                ev = 1;
                cnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("dout3k", dout3k, e0);
        chk("dout3k1", dout3k1, e1);
        chk("dout3k2", dout3k2, e2);
        chk("vout", {7'd0, vout}, {7'd0, ev});
        chk("partial", {7'd0, partial}, {7'd0, ep});
        chk("phase", {6'd0, phase}, cnt[7:0]);
        if (vout) begin
            npulse++;
            cap0 = dout3k; cap1 = dout3k1; cap2 = dout3k2; capp = partial;
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic f);
        vin = v; din = d; flush = f;
        @(posedge clk);
        @(negedge clk);
        #1;
        vin = 0; din = 0; flush = 0;
    endtask

    task automatic lanes(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic p);
        chk({name, "_l0"}, cap0, a);
        chk({name, "_l1"}, cap1, b);
        chk({name, "_l2"}, cap2, c);
        chk({name, "_partial"}, {7'd0, capp}, {7'd0, p});
    endtask

    initial begin
        rst_n = 0; vin = 0; din = 0; flush = 0;
        @(negedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            vin = 1'($urandom); flush = 1'($urandom); din = 8'($urandom);
            @(negedge clk);
            #1;
            chk("rst_phase", {6'd0, phase}, 8'd0);
            chk("rst_vout", {7'd0, vout}, 8'd0);
        end
        vin = 0; flush = 0; din = 0;
        rst_n = 1;
        cyc(0, 0, 0);

        p0 = npulse;
        for (int i = 1; i <= 6; i++) begin
            cyc(1, 8'(i), 0);
            if (i == 3) lanes("stream_g1", 8'h01, 8'h02, 8'h03, 0);
        end
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("stream_pulses", 8'(npulse - p0), 8'd2);
        lanes("stream_g2", 8'h04, 8'h05, 8'h06, 0);
        chk("stream_hold", dout3k2, 8'h06);

        p0 = npulse;
        cyc(1, 8'h11, 0);
        repeat (4) cyc(0, 0, 0);
        cyc(1, 8'h22, 0);
        cyc(0, 0, 0);
        cyc(1, 8'h33, 0);
        chk("gap_vout", {7'd0, vout}, 8'd1);
        cyc(0, 0, 0);
        chk("gap_pulses", 8'(npulse - p0), 8'd1);
        lanes("gap", 8'h11, 8'h22, 8'h33, 0);

        cyc(1, 8'hA5, 0);
        cyc(0, 0, 1);
        lanes("flush1", 8'hA5, 8'h00, 8'h00, 1);
        cyc(1, 8'h01, 0);
        cyc(1, 8'h02, 0);
        cyc(0, 0, 1);
        lanes("flush2", 8'h01, 8'h02, 8'h00, 1);
        p0 = npulse;
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("flush0_pulses", 8'(npulse - p0), 8'd0);

        cyc(1, 8'h07, 0);
        cyc(1, 8'h08, 0);
        cyc(1, 8'h09, 1);
        lanes("vf_ph2", 8'h07, 8'h08, 8'h09, 0);
        cyc(1, 8'h7F, 1);
        lanes("vf_ph0", 8'h7F, 8'h00, 8'h00, 1);
        cyc(1, 8'h3C, 0);
        cyc(1, 8'h5A, 1);
        lanes("vf_ph1", 8'h3C, 8'h5A, 8'h00, 1);
        cyc(0, 0, 0);

        p0 = npulse;
        cyc(1, 8'h10, 0);
        cyc(1, 8'h20, 0);
        #1 rst_n = 0;
        #6 rst_n = 1;
        @(negedge clk);
        #1;
        cyc(1, 8'h30, 0);
        cyc(1, 8'h40, 0);
        cyc(1, 8'h50, 0);
        cyc(0, 0, 0);
        chk("rstmid_pulses", 8'(npulse - p0), 8'd1);
        lanes("rstmid", 8'h30, 8'h40, 8'h50, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/fir_serial_to_unfolded.md
# fir_serial_to_unfolded

Serial-to-parallel front end for the 3-way unfolded FIR. Accepts one NBIT-bit sample per valid cycle and packs every three consecutive valid samples into the three lanes of one unfolded input word, raising a single-cycle valid. It sits directly upstream of the unfolded FIR: its DOUT3k/DOUT3k1/DOUT3k2/VOUT drive the filter's DIN3k/DIN3k1/DIN3k2/VIN. A flush input lets a stream end on a non-multiple of three without losing samples.

## Interface
- NBIT, 8: sample width in bits; all data ports use it.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_n  in  1  reset, asynchronous assert, active-low.
- DIN  in  NBIT  serial input sample; ignored unless VIN=1.
- VIN  in  1  input sample valid, one sample per cycle maximum.
- FLUSH  in  1  emit a partially filled group, zero-padded; single-cycle request.
- DOUT3k  out  NBIT  lane 0: oldest sample of the group, x[3k].
- DOUT3k1  out  NBIT  lane 1: x[3k+1].
- DOUT3k2  out  NBIT  lane 2: newest sample of the group, x[3k+2].
- VOUT  out  1  group valid, one-cycle pulse per emitted group.
- PARTIAL  out  1  qualifies VOUT; 1 means the group was zero-padded by FLUSH.
- PHASE  out  2  number of samples currently held, 0..2; status only.

## Operation
- State: phase counter (0,1,2), hold registers H0 and H1 (NBIT each), output registers for the three lanes plus VOUT and PARTIAL. There is no other state.
- VIN=1 at phase 0: H0<=DIN, phase->1.
- VIN=1 at phase 1: H1<=DIN, phase->2.
- VIN=1 at phase 2 (group complete):
  - DOUT3k<=H0, DOUT3k1<=H1, DOUT3k2<=DIN.
  - VOUT<=1, PARTIAL<=0, phase->0.
- FLUSH=1, VIN=0, phase 1: DOUT3k<=H0, DOUT3k1<=0, DOUT3k2<=0, VOUT<=1, PARTIAL<=1, phase->0.
- FLUSH=1, VIN=0, phase 2: DOUT3k<=H0, DOUT3k1<=H1, DOUT3k2<=0, VOUT<=1, PARTIAL<=1, phase->0.
- FLUSH=1, VIN=0, phase 0: no effect. VOUT stays 0 and nothing changes.
- FLUSH=1 and VIN=1 in the same cycle: the sample is absorbed first, then the flush applies to the result.
  - Phase 0 -> lanes H0'=DIN,0,0, PARTIAL=1.
  - Phase 1 -> lanes H0,DIN,0, PARTIAL=1.
  - Phase 2 -> normal complete group, PARTIAL=0.
  - Phase ends at 0 in every case.
- Data-out registers hold their last value between pulses. They change only on a cycle where VOUT is driven to 1.
- Hold registers are not cleared after emission. Stale H0/H1 contents never reach the outputs, because padded lanes are forced to 0.
- Data is passed through bit-exact. No arithmetic and no sign handling.
- No backpressure: the downstream FIR accepts every VOUT pulse.

## Timing
- Reset (RST_n=0, asynchronous):
  - DOUT3k, DOUT3k1, DOUT3k2 = 0.
  - VOUT = 0, PARTIAL = 0, PHASE = 0.
  - H0, H1 = 0.
- Latency: the edge that samples the third VIN (or the FLUSH) updates the lanes. VOUT is high for exactly the following cycle.
- Throughput: at most one group every 3 cycles under continuous VIN. At most one group per cycle under back-to-back FLUSH+VIN at phase 0.
- VOUT never stays high for two consecutive cycles from a single event. Back-to-back pulses occur only from back-to-back completing events.
- Gaps in VIN of any length are allowed. Phase and hold registers are retained indefinitely.
- Reset asserted mid-group discards held samples; no VOUT is produced for them. After release, the first valid sample lands in lane 0.
- PHASE reflects the registered counter, i.e. the value after the last edge.

## Test plan
- Reset: hold RST_n=0 with random DIN/VIN/FLUSH toggling -> all outputs 0; PHASE=0 throughout.
- Continuous stream: VIN=1 with DIN=1,2,3,4,5,6 on consecutive cycles.
  - Required: VOUT pulses after the 3rd and 6th samples, with lanes (1,2,3) then (4,5,6), PARTIAL=0.
  - Lanes must hold (4,5,6) afterwards.
- Gapped stream: DIN=0x11, idle 4 cycles, 0x22, idle 1 cycle, 0x33.
  - Required: exactly one VOUT, lanes (0x11,0x22,0x33), one cycle after 0x33.
- Flush cases:
  - 0xA5 then FLUSH -> lanes (0xA5,0,0), PARTIAL=1.
  - 0x01, 0x02 then FLUSH -> (0x01,0x02,0), PARTIAL=1.
  - FLUSH at phase 0 -> no VOUT.
- Simultaneous FLUSH+VIN:
  - At phase 2 with held 7,8 and DIN=9 -> (7,8,9), PARTIAL=0.
  - At phase 0 with DIN=0x7F -> (0x7F,0,0), PARTIAL=1.
- Reset mid-group: send 0x10, 0x20, pulse RST_n low, then send 0x30, 0x40, 0x50.
  - Required: only one VOUT, with lanes (0x30,0x40,0x50).
